dds_sine_gen: RTL and testbench

Direct digital synthesis sine source: a phase accumulator advanced by a per-cycle frequency tuning word drives a quarter-wave sine ROM and produces an 8-bit unsigned sample every clock. It feeds an external DAC, or a downstream digital mixer/PLL phase detector, as the reference or sweep oscillator. The output frequency is `freq_tuning_word × f_clk / 2^32`. Phase is continuous across tuning-word changes.

---
 rtl/dds_pkg.sv | 42 ++++
 rtl/sine_quarter_rom.sv | 28 ++
 rtl/dds_sine_gen.sv | 57 +++++
 tb/tb_dds_sine_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared widths and quarter-wave sine table for the DDS sine source
package dds_pkg;

    localparam int PHASE_W   = 32;
    localparam int LUT_AW    = 10;
    localparam int DATA_W    = 8;
    localparam int MAG_W     = 7;
    localparam int QTR_AW    = 8;
    localparam int QTR_DEPTH = 256;

    localparam logic [DATA_W-1:0] MIDSCALE = 8'd128;

    // pi scaled by 2^30, the fixed-point base for the table generator
    localparam longint PI_Q30 = 64'sd3373259426;

    // q[i] = round(127 * sin(2*pi*(i+0.5)/1024)) via a Q30 Taylor series
    function automatic logic [QTR_DEPTH*MAG_W-1:0] gen_quarter_table();
        logic [QTR_DEPTH*MAG_W-1:0] tbl;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint mag;
        tbl = '0;
        for (int i = 0; i < QTR_DEPTH; i++) begin
            x    = (PI_Q30 * longint'(2 * i + 1)) / 64'sd1024;
            x2   = (x * x) >>> 30;
            term = x;
            sum  = x;
            for (int n = 1; n <= 8; n++) begin
                term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
                sum  = sum + term;
            end
            mag = (64'sd127 * sum + (64'sd1 <<< 29)) >>> 30;
            tbl[i*MAG_W +: MAG_W] = mag[MAG_W-1:0];
        end
        return tbl;
    endfunction

    localparam logic [QTR_DEPTH*MAG_W-1:0] QTR_TABLE = gen_quarter_table();

endpackage

// File: rtl/sine_quarter_rom.sv
// rtl/sine_quarter_rom.sv - registered 256x7 quarter-wave sine magnitude ROM
module sine_quarter_rom
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [QTR_AW-1:0] addr,
    output logic [MAG_W-1:0]  mag
);

    logic [MAG_W-1:0] rom [QTR_DEPTH];

    always_comb begin
        for (int i = 0; i < QTR_DEPTH; i++) begin
            rom[i] = QTR_TABLE[i*MAG_W +: MAG_W];
        end
    end

    // reset value 0 is the magnitude of the phase-0 entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag <= '0;
        end else begin
            mag <= rom[addr];
        end
    end

endmodule

// File: rtl/dds_sine_gen.sv
// rtl/dds_sine_gen.sv - DDS sine source: phase accumulator, quadrant fold, offset-binary output
module dds_sine_gen
    import dds_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PHASE_W-1:0] freq_tuning_word,
    output logic [DATA_W-1:0]  dac_data
);

    logic [PHASE_W-1:0] acc;
    logic [LUT_AW-1:0]  lut_addr;
    logic [1:0]         quadrant;
    logic [QTR_AW-1:0]  rom_addr;
    logic [MAG_W-1:0]   rom_mag;
    logic               sign_s1;

    assign lut_addr = acc[PHASE_W-1 -: LUT_AW];
    assign quadrant = lut_addr[LUT_AW-1 -: 2];
    // odd quadrants walk the table backwards: 255 - i is the bitwise inverse
    assign rom_addr = quadrant[0] ? ~lut_addr[QTR_AW-1:0] : lut_addr[QTR_AW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else begin
            acc <= acc + freq_tuning_word;
        end
    end

    sine_quarter_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (rom_addr),
        .mag   (rom_mag)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_s1 <= 1'b0;
        end else begin
            sign_s1 <= quadrant[1];
        end
    end

    // lower half-wave subtracts from midscale; max magnitude 127 keeps the output >= 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dac_data <= MIDSCALE;
        end else if (sign_s1) begin
            dac_data <= MIDSCALE - {1'b0, rom_mag};
        end else begin
            dac_data <= MIDSCALE + {1'b0, rom_mag};
        end
    end

endmodule

// File: tb/tb_dds_sine_gen.sv
// tb/tb_dds_sine_gen.sv - randomized self-checking bench for dds_sine_gen against a real-valued sine model
module tb_dds_sine_gen;

    localparam real PI = 3.141592653589793;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ftw;
    logic [7:0]  dac_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] acc_m;
    logic [31:0] ph_hist[$];
    int          k_cnt;
    int          exp_dac;
    int          prev_dac;
    int          samp[1024];
    int          quarter_seq[4] = '{128, 255, 128, 1};
    int          max_jump;

    dds_sine_gen dut (
        .clk              (clk),
        .reset            (reset),
        .freq_tuning_word (ftw),
        .dac_data         (dac_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (k=%0d)", tag, got, exp, k_cnt);
        end
    endtask

    function automatic int golden_addr(input int a);
        real x;
        x = 127.0 * $sin(2.0 * PI * (real'(a) + 0.5) / 1024.0);
        if (x >= 0.0) return 128 + $rtoi(x + 0.5);
        return 128 - $rtoi(-x + 0.5);
    endfunction

    function automatic int golden(input logic [31:0] ph);
        return golden_addr(int'(ph >> 22));
    endfunction

    task automatic hold_reset(input logic [31:0] f, input int cycles);
        ftw   = f;
        reset = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            check_eq("rst_hold", int'(dac_data), 128);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        acc_m = '0;
        ph_hist = {};
        ph_hist.push_back(32'd0);
        k_cnt = 0;
    endtask

    // one clock: advance the phase model, then sample 1 time unit after the edge
    task automatic step();
        prev_dac = int'(dac_data);
        @(posedge clk);
        acc_m = acc_m + ftw;
        ph_hist.push_back(acc_m);
        if (ph_hist.size() > 3) void'(ph_hist.pop_front());
        k_cnt++;
        #1;
        exp_dac = (ph_hist.size() >= 3) ? golden(ph_hist[0]) : 128;
    endtask

    task automatic step_check(input string tag);
        step();
        check_eq(tag, int'(dac_data), exp_dac);
    endtask

    initial begin
        int d;
        int a_found;
        reset = 1'b0;
        ftw   = 32'h0200_0000;

        hold_reset(32'h0200_0000, 5);
        release_reset();
        for (int k = 1; k <= 500; k++) begin
            step_check("tone");
            samp[k] = int'(dac_data);
            if (k <= 2) check_eq("lat_mid", int'(dac_data), 128);
            if (k == 3) check_eq("rise", int'(dac_data > 8'd128), 1);
        end
        check_eq("max_k34", samp[34], 255);
        check_eq("min_k98", samp[98], 1);
        for (int k = 2; k < 258; k++) check_eq("period128", samp[k + 128], samp[k]);

        max_jump = 0;
        for (int a = 0; a < 1024; a++) begin
            d = golden_addr(a) - golden_addr((a + 16) % 1024);
            if (d < 0) d = -d;
            if (d > max_jump) max_jump = d;
        end
        ftw = 32'h0400_0000;
        for (int j = 0; j < 300; j++) begin
            step_check("fchg");
            samp[j] = int'(dac_data);
            d = int'(dac_data) - prev_dac;
            if (d < 0) d = -d;
            check_eq("fchg_jump", int'(d <= max_jump), 1);
        end
        for (int j = 10; j < 200; j++) check_eq("period64", samp[j + 64], samp[j]);

        hold_reset(32'h4000_0000, 3);
        release_reset();
        for (int k = 1; k <= 40; k++) begin
            step_check("quarter");
            if (k >= 2) check_eq("quarter_seq", int'(dac_data), quarter_seq[(k - 2) % 4]);
        end

        hold_reset(32'hFFFF_FFFF, 2);
        release_reset();
        for (int k = 1; k <= 1000; k++) begin
            step_check("wrap");
            d = int'(dac_data) - 128;
            if (d < 0) d = -d;
            check_eq("wrap_near_mid", int'(d <= 1), 1);
        end

        hold_reset(32'h0000_0000, 2);
        release_reset();
        for (int k = 1; k <= 100; k++) begin
            step_check("zero");
            check_eq("zero_const", int'(dac_data), 128);
        end

        hold_reset(32'h0200_0000, 2);
        release_reset();
        a_found = 0;
        for (int k = 1; k <= 200 && a_found == 0; k++) begin
            step_check("pre_async");
            if (dac_data != 8'd128) a_found = 1;
        end
        check_eq("async_found_nonmid", a_found, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst", int'(dac_data), 128);
        @(negedge clk);
        check_eq("async_rst_hold", int'(dac_data), 128);
        release_reset();
        for (int k = 1; k <= 40; k++) begin
            step_check("restart");
            if (k == 3) check_eq("restart_k3", int'(dac_data), golden(32'h0200_0000));
        end

        for (int t = 0; t < 8; t++) begin
            int cut;
            cut = int'($urandom_range(20, 180));
            hold_reset($urandom, 2);
            release_reset();
            for (int n = 0; n < 200; n++) begin
                if (n == cut) ftw = $urandom;
                step_check("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
